penta_code_lock: RTL and testbench

PENTA_CODE_LOCK -- requirements
Module: penta_code_lock

---
 rtl/penta_code_lock_if.sv | 20 ++
 rtl/penta_code_lock.sv | 178 +++++++++++++++++
 tb/tb_penta_code_lock.sv | 155 +++++++++++++++
 3 files changed

// File: rtl/penta_code_lock_if.sv
// rtl/penta_code_lock_if.sv - key/tick inputs and status outputs of the penta code lock
interface penta_code_lock_if;
    logic       tick;
    logic [4:0] key;
    logic       unlock;
    logic       alarm;
    logic       busy;
    logic [3:0] progress;
    logic       err_pulse;

    modport master (
        output tick, key,
        input  unlock, alarm, busy, progress, err_pulse
    );

    modport slave (
        input  tick, key,
        output unlock, alarm, busy, progress, err_pulse
    );
endinterface

// File: rtl/penta_code_lock.sv
// rtl/penta_code_lock.sv - five-key code lock FSM; optional lockout via PENTA_LOCKOUT_EN
module penta_code_lock #(
    parameter int          CODE_LEN      = 4,
    parameter logic [23:0] CODE          = 24'h000819,
    parameter int          ENTRY_TIMEOUT = 8,
    parameter int          OPEN_TICKS    = 16,
    parameter int          MAX_FAIL      = 3,
    parameter int          LOCKOUT_TICKS = 32
) (
    input  logic               sysclk,
    input  logic               reset,
    penta_code_lock_if.slave   bus
);
    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] ENTRY = 2'd1;
    localparam logic [1:0] OPEN  = 2'd2;
`ifdef PENTA_LOCKOUT_EN
    localparam logic [1:0] LOCKOUT = 2'd3;
    localparam int FW = $clog2(MAX_FAIL + 1);
`endif
    // One shared tick counter serves every timed state, so size it for the sum.
    localparam int TW = $clog2(ENTRY_TIMEOUT + OPEN_TICKS + LOCKOUT_TICKS + 1);

    if (CODE_LEN < 1 || CODE_LEN > 8 || MAX_FAIL < 1 || ENTRY_TIMEOUT < 1 ||
        OPEN_TICKS < 1 || LOCKOUT_TICKS < 1) begin : g_bad_param
        $error("penta_code_lock: parameter out of range");
    end

    logic [1:0]    state_q, state_d;
    logic [3:0]    progress_q, progress_d;
    logic          mismatch_q, mismatch_d;
    logic [TW-1:0] tick_cnt_q, tick_cnt_d;
    logic          unlock_q, unlock_d;
    logic          busy_q, busy_d;
    logic          err_pulse_q, err_pulse_d;
`ifdef PENTA_LOCKOUT_EN
    logic [FW-1:0] fail_q, fail_d;
    logic          alarm_q, alarm_d;
`endif

    logic          key_ev, key_onehot, miss_acc;
    logic [2:0]    key_digit, exp_digit;
    logic [3:0]    prog_inc;
    logic [TW-1:0] tick_inc;

    always_comb begin
        key_ev     = |bus.key;
        key_onehot = key_ev && ((bus.key & (bus.key - 5'd1)) == 5'd0);
        key_digit  = 3'd0;
        for (int i = 0; i < 5; i++)
            if (bus.key[i]) key_digit = 3'(i);
        exp_digit = CODE[2:0];
        for (int i = 0; i < 8; i++)
            if (progress_q == 4'(i)) exp_digit = CODE[3*i +: 3];
        // Multi-hot presses still consume a slot but can never match.
        miss_acc = mismatch_q | !key_onehot | (key_digit != exp_digit);
        prog_inc = progress_q + 4'd1;
        tick_inc = tick_cnt_q + TW'(1);

        state_d     = state_q;
        progress_d  = progress_q;
        mismatch_d  = mismatch_q;
        tick_cnt_d  = tick_cnt_q;
        err_pulse_d = 1'b0;
`ifdef PENTA_LOCKOUT_EN
        fail_d      = fail_q;
`endif
        case (state_q)
            IDLE, ENTRY: begin
                if (key_ev) begin
                    state_d    = ENTRY;
                    progress_d = prog_inc;
                    mismatch_d = miss_acc;
                    tick_cnt_d = '0;
                    if (prog_inc == 4'(CODE_LEN)) begin
                        progress_d = 4'd0;
                        mismatch_d = 1'b0;
                        if (!miss_acc) begin
                            state_d = OPEN;
`ifdef PENTA_LOCKOUT_EN
                            fail_d  = '0;
`endif
                        end else begin
                            state_d     = IDLE;
                            err_pulse_d = 1'b1;
`ifdef PENTA_LOCKOUT_EN
                            fail_d = (fail_q == FW'(MAX_FAIL)) ? fail_q : fail_q + FW'(1);
                            if (fail_d == FW'(MAX_FAIL)) state_d = LOCKOUT;
`endif
                        end
                    end
                end else if (state_q == ENTRY && bus.tick) begin
                    tick_cnt_d = tick_inc;
                    if (tick_inc == TW'(ENTRY_TIMEOUT)) begin
                        state_d     = IDLE;
                        progress_d  = 4'd0;
                        mismatch_d  = 1'b0;
                        tick_cnt_d  = '0;
                        err_pulse_d = 1'b1;
                    end
                end
            end
            OPEN: begin
                progress_d = 4'd0;
                if (bus.tick) begin
                    tick_cnt_d = tick_inc;
                    if (tick_inc == TW'(OPEN_TICKS)) begin
                        state_d    = IDLE;
                        tick_cnt_d = '0;
                    end
                end
            end
`ifdef PENTA_LOCKOUT_EN
            LOCKOUT: begin
                progress_d = 4'd0;
                if (bus.tick) begin
                    tick_cnt_d = tick_inc;
                    if (tick_inc == TW'(LOCKOUT_TICKS)) begin
                        state_d    = IDLE;
                        tick_cnt_d = '0;
                        fail_d     = '0;
                    end
                end
            end
`endif
            default: begin
                state_d    = IDLE;
                progress_d = 4'd0;
                mismatch_d = 1'b0;
                tick_cnt_d = '0;
            end
        endcase

        unlock_d = (state_d == OPEN);
        busy_d   = (state_d != IDLE);
`ifdef PENTA_LOCKOUT_EN
        alarm_d  = (state_d == LOCKOUT);
`endif
    end

    always_ff @(posedge sysclk) begin
        if (reset) begin
            state_q     <= IDLE;
            progress_q  <= 4'd0;
            mismatch_q  <= 1'b0;
            tick_cnt_q  <= '0;
            unlock_q    <= 1'b0;
            busy_q      <= 1'b0;
            err_pulse_q <= 1'b0;
`ifdef PENTA_LOCKOUT_EN
            fail_q      <= '0;
            alarm_q     <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            progress_q  <= progress_d;
            mismatch_q  <= mismatch_d;
            tick_cnt_q  <= tick_cnt_d;
            unlock_q    <= unlock_d;
            busy_q      <= busy_d;
            err_pulse_q <= err_pulse_d;
`ifdef PENTA_LOCKOUT_EN
            fail_q      <= fail_d;
            alarm_q     <= alarm_d;
`endif
        end
    end

    assign bus.unlock    = unlock_q;
    assign bus.busy      = busy_q;
    assign bus.progress  = progress_q;
    assign bus.err_pulse = err_pulse_q;
`ifdef PENTA_LOCKOUT_EN
    assign bus.alarm     = alarm_q;
`else
    assign bus.alarm     = 1'b0;
`endif
endmodule

// File: tb/tb_penta_code_lock.sv
// tb/tb_penta_code_lock.sv - scoreboard bench for penta_code_lock (default parameters)
module tb_penta_code_lock;
    logic sysclk = 1'b0;
    logic reset;
    always #5 sysclk = ~sysclk;

    penta_code_lock_if bus();
    penta_code_lock dut (.sysclk(sysclk), .reset(reset), .bus(bus));

    typedef struct packed {
        logic       unlock;
        logic       alarm;
        logic       busy;
        logic [3:0] progress;
        logic       err;
    } exp_t;

    exp_t sb_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   cyc_n = 0;

    task automatic check_eq(input string tag, input logic [7:0] got, input logic [7:0] want);
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s cycle %0d: got %0d expected %0d", tag, cyc_n, got, want);
        end
    endtask

    function automatic exp_t ex(input bit u, input bit a, input bit b, input int p, input bit e);
        exp_t x;
        x.unlock = u; x.alarm = a; x.busy = b; x.progress = 4'(p); x.err = e;
        return x;
    endfunction

    function automatic logic [4:0] kd(input int d);
        return 5'(1 << d);
    endfunction

    task automatic step(input bit r, input bit t, input logic [4:0] k, input exp_t e);
        exp_t x;
        reset    = r;
        bus.tick = t;
        bus.key  = k;
        sb_q.push_back(e);
        @(posedge sysclk);
        #1;
        cyc_n++;
        if (sb_q.size() == 0) begin
            check_eq("scoreboard_empty", 8'd1, 8'd0);
        end else begin
            x = sb_q.pop_front();
            check_eq("unlock",    8'(bus.unlock),    8'(x.unlock));
            check_eq("alarm",     8'(bus.alarm),     8'(x.alarm));
            check_eq("busy",      8'(bus.busy),      8'(x.busy));
            check_eq("progress",  8'(bus.progress),  8'(x.progress));
            check_eq("err_pulse", 8'(bus.err_pulse), 8'(x.err));
        end
    endtask

    task automatic attempt(input logic [4:0] k0, input logic [4:0] k1, input logic [4:0] k2,
                           input logic [4:0] k3, input exp_t fin);
        step(0, 0, k0, ex(0, 0, 1, 1, 0));
        step(0, 0, k1, ex(0, 0, 1, 2, 0));
        step(0, 0, k2, ex(0, 0, 1, 3, 0));
        step(0, 0, k3, fin);
    endtask

    exp_t z, opn, fail_e;

    initial begin
        z      = ex(0, 0, 0, 0, 0);
        opn    = ex(1, 0, 1, 0, 0);
        fail_e = ex(0, 0, 0, 0, 1);
        bus.tick = 1'b0;
        bus.key  = 5'd0;
        reset    = 1'b1;

        step(1, 1, kd(1), z);
        step(1, 0, 5'b11111, z);

        // correct code, ticks interleaved; tick with the last key must not count
        step(0, 1, kd(1), ex(0, 0, 1, 1, 0));
        step(0, 1, 5'd0,  ex(0, 0, 1, 1, 0));
        step(0, 0, kd(3), ex(0, 0, 1, 2, 0));
        step(0, 1, 5'd0,  ex(0, 0, 1, 2, 0));
        step(0, 0, kd(0), ex(0, 0, 1, 3, 0));
        step(0, 1, kd(4), opn);
        for (int i = 1; i <= 16; i++) begin
            step(0, 1, 5'd0, (i < 16) ? opn : z);
            if (i < 16) step(0, 0, (i % 4 == 0) ? kd(1) : 5'd0, opn);
        end
        step(0, 0, 5'd0, z);

        // wrong third digit: no early rejection
        attempt(kd(1), kd(3), kd(2), kd(4), fail_e);
        step(0, 0, 5'd0, z);

        // timeout, with a key+tick restart in the middle
        step(0, 1, kd(1), ex(0, 0, 1, 1, 0));
        step(0, 0, kd(3), ex(0, 0, 1, 2, 0));
        for (int i = 1; i <= 7; i++) begin
            step(0, 1, 5'd0, ex(0, 0, 1, 2, 0));
            if (i % 2 == 1) step(0, 0, 5'd0, ex(0, 0, 1, 2, 0));
        end
        step(0, 1, kd(0), ex(0, 0, 1, 3, 0));
        for (int i = 1; i <= 8; i++)
            step(0, 1, 5'd0, (i < 8) ? ex(0, 0, 1, 3, 0) : fail_e);
        step(0, 0, 5'd0, z);

        // multi-hot first entry
        attempt(5'b00011, kd(3), kd(0), kd(4), fail_e);
        step(0, 0, 5'd0, z);

        // reset mid-ENTRY, then a clean unlock
        step(0, 0, kd(1), ex(0, 0, 1, 1, 0));
        step(0, 0, kd(3), ex(0, 0, 1, 2, 0));
        step(1, 1, kd(0), z);
        attempt(kd(1), kd(3), kd(0), kd(4), opn);
        step(0, 1, 5'd0, opn);
        step(0, 1, kd(2), opn);
        step(1, 1, 5'd0, z);
        attempt(kd(1), kd(3), kd(0), kd(4), opn);
        step(1, 0, 5'd0, z);

        // three consecutive failures
        attempt(kd(0), kd(3), kd(0), kd(4), fail_e);
        step(0, 0, 5'd0, z);
        attempt(kd(1), kd(1), kd(0), kd(4), fail_e);
        step(0, 0, 5'd0, z);
`ifdef PENTA_LOCKOUT_EN
        attempt(kd(1), kd(3), kd(0), kd(3), ex(0, 1, 1, 0, 1));
        step(0, 0, kd(1), ex(0, 1, 1, 0, 0));
        for (int i = 1; i <= 32; i++) begin
            step(0, 1, (i % 5 == 0) ? kd(1) : 5'd0, (i < 32) ? ex(0, 1, 1, 0, 0) : z);
            if (i < 32) step(0, 0, kd(i % 5), ex(0, 1, 1, 0, 0));
        end
`else
        attempt(kd(1), kd(3), kd(0), kd(3), fail_e);
`endif
        step(0, 0, 5'd0, z);

        // fail count is back to zero: two more failures stay out of lockout
        attempt(kd(4), kd(3), kd(0), kd(4), fail_e);
        step(0, 0, 5'd0, z);
        attempt(kd(1), kd(3), kd(4), kd(4), fail_e);
        step(0, 0, 5'd0, z);
        attempt(kd(1), kd(3), kd(0), kd(4), opn);
        step(0, 0, 5'd0, opn);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
